// File: rtl/core_pkg.sv
// Shared types and constants for the core preempt sequencer.
//   preempt_state_e : sequencer FSM states
//   preempt_req_t   : one decoder slot's preempt request fields
//   arf_onehot()    : register index to one-hot dirty-clear mask
package core_pkg;

    localparam int ARF_N     = 16;
    localparam int ARF_IDX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM,
        ST_WB,
        ST_JUMP,
        ST_HALTED
    } preempt_state_e;

    typedef struct packed {
        logic halt;
        logic lsu_en;
        logic lsu_wen;
        logic lsu_kind;
        logic jump_en;
        logic jump_kind;
    } preempt_req_t;

    function automatic logic [ARF_N-1:0] arf_onehot(input logic [ARF_IDX_W-1:0] idx);
        logic [ARF_N-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/core_prio_enc.sv
// Lowest-index priority encoder.
//   req    : request vector, bit 0 has highest priority
//   valid  : any request present
//   idx    : binary index of the winning request
//   onehot : one-hot mask of the winning request
module core_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    always_comb begin
        valid  = |req;
        idx    = '0;
        onehot = '0;
        // Walk from the top down so the lowest set bit is the last to write.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx       = IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_preempt_ctrl.sv
// Sequencer for side-effecting operations raised by the decoder slots.
// Grants the oldest requesting slot and runs one operation at a time:
// data-memory load/store (with load write-back), PC redirect, or halt.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_*_i, slot_*_i     : per-slot preempt requests and operands
//   mem_*_o / mem_*_i     : single-port data-memory handshake
//   arf_*_o, clr_dirty_o  : load write-back and dirty-bit clear
//   jump_o, jump_target_o : PC redirect pulse
//   grant_o               : one-hot acceptance pulse
//   busy_o, halted_o      : cascade stall, halt status
//   resume_i              : leave halt
// Every output is driven from a flop.
module core_preempt_ctrl
    import core_pkg::*;
#(
    parameter int N_SLOT = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [N_SLOT-1:0]                    req_halt_i,
    input  logic [N_SLOT-1:0]                    req_lsu_en_i,
    input  logic [N_SLOT-1:0]                    req_lsu_wen_i,
    input  logic [N_SLOT-1:0]                    req_lsu_kind_i,
    input  logic [N_SLOT-1:0]                    req_jump_en_i,
    input  logic [N_SLOT-1:0]                    req_jump_kind_i,
    input  logic [N_SLOT-1:0][ADDR_W-1:0]        slot_imm_i,
    input  logic [N_SLOT-1:0][ARF_IDX_W-1:0]     slot_rd_i,
    input  logic [N_SLOT-1:0][DATA_W-1:0]        slot_rd_val_i,
    input  logic [N_SLOT-1:0][DATA_W-1:0]        slot_rt_val_i,
    output logic                                 mem_req_o,
    output logic                                 mem_wen_o,
    output logic [ADDR_W-1:0]                    mem_addr_o,
    output logic [DATA_W-1:0]                    mem_wdata_o,
    input  logic                                 mem_ack_i,
    input  logic [DATA_W-1:0]                    mem_rdata_i,
    output logic                                 arf_wen_o,
    output logic [ARF_IDX_W-1:0]                 arf_waddr_o,
    output logic [DATA_W-1:0]                    arf_wdata_o,
    output logic [ARF_N-1:0]                     clr_dirty_o,
    output logic                                 jump_o,
    output logic [ADDR_W-1:0]                    jump_target_o,
    output logic [N_SLOT-1:0]                    grant_o,
    output logic                                 busy_o,
    output logic                                 halted_o,
    input  logic                                 resume_i
);

    localparam int SLOT_W = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;

    // ---------------------------------------------------------------
    // Per-slot request bundling and oldest-slot arbitration
    // ---------------------------------------------------------------
    preempt_req_t [N_SLOT-1:0] req;
    logic [N_SLOT-1:0]         active;

    for (genvar g = 0; g < N_SLOT; g++) begin : g_slot
        assign req[g] = '{halt:      req_halt_i[g],
                          lsu_en:    req_lsu_en_i[g],
                          lsu_wen:   req_lsu_wen_i[g],
                          lsu_kind:  req_lsu_kind_i[g],
                          jump_en:   req_jump_en_i[g],
                          jump_kind: req_jump_kind_i[g]};
        assign active[g] = req[g].halt | req[g].lsu_en | req[g].jump_en;
    end

    logic              win_vld;
    logic [SLOT_W-1:0] win_idx;
    logic [N_SLOT-1:0] win_oh;

    core_prio_enc #(.N(N_SLOT), .IDX_W(SLOT_W)) u_prio (
        .req    (active),
        .valid  (win_vld),
        .idx    (win_idx),
        .onehot (win_oh)
    );

    preempt_req_t sel;
    assign sel = req[win_idx];

    // ---------------------------------------------------------------
    // State and latched operation fields
    // ---------------------------------------------------------------
    preempt_state_e       state, state_n;
    logic                 lat_wen, lat_wen_n;
    logic [ARF_IDX_W-1:0] lat_rd, lat_rd_n;
    logic [ADDR_W-1:0]    lat_addr, lat_addr_n;
    logic [DATA_W-1:0]    lat_wdata, lat_wdata_n;
    logic [ADDR_W-1:0]    lat_target, lat_target_n;
    logic [DATA_W-1:0]    rdata_q, rdata_n;

    // Next values of the registered outputs
    logic                 mem_req_n, mem_wen_n;
    logic [ADDR_W-1:0]    mem_addr_n;
    logic [DATA_W-1:0]    mem_wdata_n;
    logic                 arf_wen_n;
    logic [ARF_IDX_W-1:0] arf_waddr_n;
    logic [DATA_W-1:0]    arf_wdata_n;
    logic [ARF_N-1:0]     clr_dirty_n;
    logic                 jump_n;
    logic [ADDR_W-1:0]    jump_target_n;
    logic [N_SLOT-1:0]    grant_n;

    always_comb begin
        state_n      = state;
        lat_wen_n    = lat_wen;
        lat_rd_n     = lat_rd;
        lat_addr_n   = lat_addr;
        lat_wdata_n  = lat_wdata;
        lat_target_n = lat_target;
        rdata_n      = rdata_q;
        grant_n      = '0;

        unique case (state)
            ST_IDLE: begin
                if (win_vld) begin
                    grant_n      = win_oh;
                    lat_wen_n    = sel.lsu_wen;
                    lat_rd_n     = slot_rd_i[win_idx];
                    lat_addr_n   = sel.lsu_kind ? slot_imm_i[win_idx]
                                                : ADDR_W'(slot_rt_val_i[win_idx]);
                    lat_wdata_n  = slot_rd_val_i[win_idx];
                    lat_target_n = sel.jump_kind ? slot_imm_i[win_idx]
                                                 : ADDR_W'(slot_rd_val_i[win_idx]);
                    if (sel.halt)         state_n = ST_HALTED;
                    else if (sel.lsu_en)  state_n = ST_MEM;
                    else if (sel.jump_en) state_n = ST_JUMP;
                end
            end
            ST_MEM: begin
                if (mem_ack_i) begin
                    if (lat_wen) begin
                        state_n = ST_IDLE;
                    end else begin
                        rdata_n = mem_rdata_i;
                        state_n = ST_WB;
                    end
                end
            end
            ST_WB:     state_n = ST_IDLE;
            ST_JUMP:   state_n = ST_IDLE;
            ST_HALTED: if (resume_i) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase

        // Outputs reflect the state being entered, so they line up with
        // the state register on the following cycle.
        mem_req_n     = (state_n == ST_MEM);
        mem_wen_n     = mem_req_n & lat_wen_n;
        mem_addr_n    = mem_req_n ? lat_addr_n : '0;
        mem_wdata_n   = mem_wen_n ? lat_wdata_n : '0;
        arf_wen_n     = (state_n == ST_WB) && (lat_rd_n != '0);
        arf_waddr_n   = (state_n == ST_WB) ? lat_rd_n : '0;
        arf_wdata_n   = (state_n == ST_WB) ? rdata_n : '0;
        clr_dirty_n   = (state_n == ST_WB) ? arf_onehot(lat_rd_n) : '0;
        jump_n        = (state_n == ST_JUMP);
        jump_target_n = jump_n ? lat_target_n : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            lat_wen       <= 1'b0;
            lat_rd        <= '0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            lat_target    <= '0;
            rdata_q       <= '0;
            mem_req_o     <= 1'b0;
            mem_wen_o     <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            arf_wen_o     <= 1'b0;
            arf_waddr_o   <= '0;
            arf_wdata_o   <= '0;
            clr_dirty_o   <= '0;
            jump_o        <= 1'b0;
            jump_target_o <= '0;
            grant_o       <= '0;
            busy_o        <= 1'b0;
            halted_o      <= 1'b0;
        end else begin
            state         <= state_n;
            lat_wen       <= lat_wen_n;
            lat_rd        <= lat_rd_n;
            lat_addr      <= lat_addr_n;
            lat_wdata     <= lat_wdata_n;
            lat_target    <= lat_target_n;
            rdata_q       <= rdata_n;
            mem_req_o     <= mem_req_n;
            mem_wen_o     <= mem_wen_n;
            mem_addr_o    <= mem_addr_n;
            mem_wdata_o   <= mem_wdata_n;
            arf_wen_o     <= arf_wen_n;
            arf_waddr_o   <= arf_waddr_n;
            arf_wdata_o   <= arf_wdata_n;
            clr_dirty_o   <= clr_dirty_n;
            jump_o        <= jump_n;
            jump_target_o <= jump_target_n;
            grant_o       <= grant_n;
            busy_o        <= (state_n != ST_IDLE);
            halted_o      <= (state_n == ST_HALTED);
        end
    end

endmodule
